// File: rtl/motor_enc_decoder_if.sv
// ---------------------------------------------------------------------------
// motor_enc_decoder_if
// Bundles the encoder lines, the control requests and the measurement results
// of the quadrature encoder front end into one connection.
//
// Parameters:
//   POS_W  width of the signed position result
//   SPD_W  width of the signed speed result
//
// Signals:
//   enc_a, enc_b  raw encoder channels (asynchronous to the system clock)
//   clr_pos       one-cycle request to zero the position count
//   err_clr       one-cycle request to clear the sticky error flag
//   position      signed accumulated x4 step count
//   speed         signed step count over the last completed window
//   speed_vld     one-cycle pulse when speed updates
//   direct        direction of the last valid step (1 = forward)
//   err           sticky illegal-transition flag
//   stall         motor considered stopped
//
// Modports:
//   master  the controller / motor side that drives encoder lines and requests
//   slave   the decoder itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface motor_enc_decoder_if #(
  parameter int POS_W = 16,
  parameter int SPD_W = 16
);
  logic             enc_a;
  logic             enc_b;
  logic             clr_pos;
  logic             err_clr;
  logic [POS_W-1:0] position;
  logic [SPD_W-1:0] speed;
  logic             speed_vld;
  logic             direct;
  logic             err;
  logic             stall;

  modport master (
    output enc_a, enc_b, clr_pos, err_clr,
    input  position, speed, speed_vld, direct, err, stall
  );

  modport slave (
    input  enc_a, enc_b, clr_pos, err_clr,
    output position, speed, speed_vld, direct, err, stall
  );
endinterface

// File: rtl/motor_enc_decoder.sv
// ---------------------------------------------------------------------------
// motor_enc_decoder
// Quadrature encoder front end for the DC motor channel. Synchronizes the
// encoder A/B lines, decodes x4 quadrature steps into a wrapping signed
// position, tracks direction, measures steps per gate window (saturating),
// flags illegal double transitions (sticky) and detects stalls from a run of
// zero-speed windows.
//
// Ports:
//   sclk   system clock, all logic on its rising edge
//   s_rst  synchronous active-high reset
//   bus    motor_enc_decoder_if.slave: enc_a/enc_b/clr_pos/err_clr in,
//          position/speed/speed_vld/direct/err/stall out
//
// Optional feature macro: MOTOR_ENC_FILTER_EN
//   When defined, each synchronized channel passes through a glitch filter
//   that only follows a new level after it has been stable for FILT_LEN
//   consecutive cycles. When undefined, no filter logic exists.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module motor_enc_decoder #(
  parameter int POS_W       = 16,
  parameter int SPD_W       = 16,
  parameter int GATE_CYC    = 500000,
  parameter int STALL_GATES = 10,
  parameter int FILT_LEN    = 4
) (
  input  logic              sclk,
  input  logic              s_rst,
  motor_enc_decoder_if.slave bus
);

  localparam int GATE_W = $clog2(GATE_CYC);
  localparam int ZERO_W = $clog2(STALL_GATES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
  localparam logic [ZERO_W-1:0] ZERO_MAX  = ZERO_W'(STALL_GATES);

  // Out-of-range parameters elaborate an empty marker block.
  if (GATE_CYC < 2 || STALL_GATES < 1 || FILT_LEN < 1) begin : g_paramOutOfRange
  end

  logic [1:0]       r_syncA;
  logic [1:0]       r_syncB;
  logic [1:0]       w_cond;
  logic [1:0]       r_prevPair;
  logic             w_stepFwd;
  logic             w_stepRev;
  logic             w_illegal;
  logic [POS_W-1:0] w_posDelta;
  logic [SPD_W:0]   w_accWide;
  logic [SPD_W-1:0] w_accSat;
  logic [POS_W-1:0] r_position;
  logic             r_direct;
  logic             r_err;
  logic [GATE_W-1:0] r_gateCnt;
  logic [SPD_W-1:0] r_acc;
  logic [SPD_W-1:0] r_speed;
  logic             r_speedVld;
  logic [ZERO_W-1:0] r_zeroCnt;

  // Two-flop synchronizers bring the asynchronous encoder lines into sclk.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_syncA <= 2'b00;
      r_syncB <= 2'b00;
    end else begin
      r_syncA <= {r_syncA[0], bus.enc_a};
      r_syncB <= {r_syncB[0], bus.enc_b};
    end
  end

`ifdef MOTOR_ENC_FILTER_EN
  localparam int FCNT_W = $clog2(FILT_LEN + 1);

  logic [1:0]        w_syncPair;
  logic [1:0]        r_filt;
  logic [FCNT_W-1:0] r_filtCnt [2];

  assign w_syncPair = {r_syncA[1], r_syncB[1]};

  // Each channel counts consecutive cycles on which the synchronized level
  // disagrees with the filtered level; the filtered level follows only on the
  // FILT_LEN-th such cycle, so any shorter excursion is discarded.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_filt <= 2'b00;
      for (int ch = 0; ch < 2; ch++) r_filtCnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (w_syncPair[ch] != r_filt[ch]) begin
          if (r_filtCnt[ch] == FCNT_W'(FILT_LEN - 1)) begin
            r_filt[ch]    <= w_syncPair[ch];
            r_filtCnt[ch] <= '0;
          end else begin
            r_filtCnt[ch] <= r_filtCnt[ch] + FCNT_W'(1);
          end
        end else begin
          r_filtCnt[ch] <= '0;
        end
      end
    end
  end

  assign w_cond = r_filt;
`else
  assign w_cond = {r_syncA[1], r_syncB[1]};
`endif

  // Gray-code decode of previous vs current {A,B}: A leading B is forward,
  // B leading A is reverse, and both bits changing at once is illegal.
  always_comb begin
    w_stepFwd = 1'b0;
    w_stepRev = 1'b0;
    w_illegal = 1'b0;
    case ({r_prevPair, w_cond})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_stepFwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_stepRev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
      default: ;
    endcase
  end

  // The step as a two's complement delta for position, and the window
  // accumulator computed one bit wider so overflow shows up as a sign
  // disagreement between the top two bits and can be clamped.
  always_comb begin
    w_posDelta = '0;
    w_accWide  = {r_acc[SPD_W-1], r_acc};
    if (w_stepFwd) begin
      w_posDelta = POS_W'(1);
      w_accWide  = {r_acc[SPD_W-1], r_acc} + (SPD_W+1)'(1);
    end else if (w_stepRev) begin
      w_posDelta = '1;
      w_accWide  = {r_acc[SPD_W-1], r_acc} + {(SPD_W+1){1'b1}};
    end
    if (w_accWide[SPD_W] != w_accWide[SPD_W-1]) begin
      w_accSat = w_accWide[SPD_W] ? {1'b1, {(SPD_W-1){1'b0}}}
                                  : {1'b0, {(SPD_W-1){1'b1}}};
    end else begin
      w_accSat = w_accWide[SPD_W-1:0];
    end
  end

  // Position, direction and sticky error. A position clear drops the step
  // of the same cycle; an illegal step beats an error clear.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_prevPair <= 2'b00;
      r_position <= '0;
      r_direct   <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_prevPair <= w_cond;
      if (bus.clr_pos) r_position <= '0;
      else             r_position <= r_position + w_posDelta;
      if (w_stepFwd || w_stepRev) r_direct <= w_stepFwd;
      if (w_illegal)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end

  // Speed gate: on the last cycle of each window the accumulator, including
  // this cycle's step, is published and restarted. The zero-window run length
  // is updated from the value being published on that same edge.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_gateCnt  <= '0;
      r_acc      <= '0;
      r_speed    <= '0;
      r_speedVld <= 1'b0;
      r_zeroCnt  <= '0;
    end else if (r_gateCnt == GATE_LAST) begin
      r_gateCnt  <= '0;
      r_acc      <= '0;
      r_speed    <= w_accSat;
      r_speedVld <= 1'b1;
      if (w_accSat == '0) begin
        if (r_zeroCnt != ZERO_MAX) r_zeroCnt <= r_zeroCnt + ZERO_W'(1);
      end else begin
        r_zeroCnt <= '0;
      end
    end else begin
      r_gateCnt  <= r_gateCnt + GATE_W'(1);
      r_acc      <= w_accSat;
      r_speedVld <= 1'b0;
    end
  end

  assign bus.position  = r_position;
  assign bus.speed     = r_speed;
  assign bus.speed_vld = r_speedVld;
  assign bus.direct    = r_direct;
  assign bus.err       = r_err;
  assign bus.stall     = (r_zeroCnt == ZERO_MAX);

endmodule
